// File: rtl/id_ex_stage_pkg.sv
// Shared control-vector layout and opcode constants for the control unit and the ID/EX stage.
// Bit 13 of the control vector is reserved and travels through the pipeline untouched.
package id_ex_stage_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int FUNCT_W   = 4;
    localparam int CTRL_W    = 14;

    // Control-vector bit offsets
    localparam int CTRL_JUMP       = 0;
    localparam int CTRL_BRANCH     = 1;
    localparam int CTRL_MEMWRITE   = 2;
    localparam int CTRL_MEMREAD    = 3;
    localparam int CTRL_REGWRITE   = 4;
    localparam int CTRL_ALUSRC     = 5;
    localparam int CTRL_REGSRC_LSB = 6;
    localparam int CTRL_ALUOP_LSB  = 8;
    localparam int CTRL_VREG_RD    = 10;
    localparam int CTRL_VREG_RS1   = 11;
    localparam int CTRL_VREG_RS2   = 12;

    typedef struct packed {
        logic       rsvd;
        logic [2:0] valid_reg;   // {rs2, rs1, rd}
        logic [1:0] alu_op;
        logic [1:0] reg_src;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
    } ctrl_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard: a load in EX whose rd feeds a source register the decode
// instruction actually reads. Writes to x0 and unused source fields never count.
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 id_valid,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    output logic                 load_use
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);

    assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid
                      && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and a saturating stall counter.
// Latency 1 cycle; holds while EX stalls, decode sees id_ready low on stall, hazard, flush or reset.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [CTRL_W-1:0]    id_ctrl,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [FUNCT_W-1:0]   id_funct,
    input  logic                 flush,
    input  logic                 ex_ready,
    output logic                 ex_valid,
    output logic [CTRL_W-1:0]    ex_ctrl,
    output logic [REG_IDX_W-1:0] ex_rs1,
    output logic [REG_IDX_W-1:0] ex_rs2,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_rs1_data,
    output logic [XLEN-1:0]      ex_rs2_data,
    output logic [XLEN-1:0]      ex_imm,
    output logic [FUNCT_W-1:0]   ex_funct,
    output logic                 load_use_stall,
    output logic [31:0]          stall_count
);

    logic        hazard;
    logic        ex_free;
    logic        accept;
    logic [31:0] stall_cnt_q;

    load_use_detect u_load_use_detect (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl[CTRL_MEMREAD]),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_use_rs1  (id_ctrl[CTRL_VREG_RS1]),
        .id_use_rs2  (id_ctrl[CTRL_VREG_RS2]),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .load_use    (hazard)
    );

    assign load_use_stall = hazard;
    assign ex_free        = !ex_valid || ex_ready;
    assign id_ready       = !rst && ex_free && !hazard && !flush;
    assign accept         = id_valid && id_ready;

    // Priority: reset, flush, new instruction, drain to bubble; otherwise hold for EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_funct    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (accept) begin
            ex_valid    <= 1'b1;
            ex_ctrl     <= id_ctrl;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_funct    <= id_funct;
        end else if (ex_free) begin
            // Bubble: clearing ctrl keeps writes/branches from leaking out of an empty slot.
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (hazard && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: instruction-level model checked every cycle plus literal spot checks.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 id_valid;
    logic                 id_ready;
    logic [CTRL_W-1:0]    id_ctrl;
    logic [REG_IDX_W-1:0] id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0]      id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [FUNCT_W-1:0]   id_funct;
    logic                 flush;
    logic                 ex_ready;
    logic                 ex_valid;
    logic [CTRL_W-1:0]    ex_ctrl;
    logic [REG_IDX_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [XLEN-1:0]      ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [FUNCT_W-1:0]   ex_funct;
    logic                 load_use_stall;
    logic [31:0]          stall_count;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_ctrl        (id_ctrl),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_pc          (id_pc),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .id_imm         (id_imm),
        .id_funct       (id_funct),
        .flush          (flush),
        .ex_ready       (ex_ready),
        .ex_valid       (ex_valid),
        .ex_ctrl        (ex_ctrl),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_rd          (ex_rd),
        .ex_pc          (ex_pc),
        .ex_rs1_data    (ex_rs1_data),
        .ex_rs2_data    (ex_rs2_data),
        .ex_imm         (ex_imm),
        .ex_funct       (ex_funct),
        .load_use_stall (load_use_stall),
        .stall_count    (stall_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Small control-unit model: opcode -> control vector.
    function automatic logic [CTRL_W-1:0] ctrl_of(input logic [6:0] opc);
        ctrl_t c;
        c = '0;
        case (opc)
            OPC_LOAD:   begin c.valid_reg = 3'b011; c.reg_src = 2'b01; c.alu_src = 1'b1;
                              c.reg_write = 1'b1; c.mem_read = 1'b1; end
            OPC_STORE:  begin c.valid_reg = 3'b110; c.alu_src = 1'b1; c.mem_write = 1'b1; end
            OPC_OP_IMM: begin c.valid_reg = 3'b011; c.alu_op = 2'b10; c.alu_src = 1'b1;
                              c.reg_write = 1'b1; end
            OPC_OP:     begin c.valid_reg = 3'b111; c.alu_op = 2'b10; c.reg_write = 1'b1; end
            OPC_LUI:    begin c.valid_reg = 3'b001; c.reg_src = 2'b10; c.alu_src = 1'b1;
                              c.reg_write = 1'b1; end
            OPC_AUIPC:  begin c.valid_reg = 3'b001; c.alu_src = 1'b1; c.reg_write = 1'b1; end
            OPC_BRANCH: begin c.valid_reg = 3'b110; c.alu_op = 2'b01; c.branch = 1'b1; end
            OPC_JAL:    begin c.valid_reg = 3'b001; c.reg_src = 2'b11; c.reg_write = 1'b1;
                              c.jump = 1'b1; end
            OPC_JALR:   begin c.valid_reg = 3'b011; c.reg_src = 2'b11; c.reg_write = 1'b1;
                              c.jump = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    // Instruction-level model: which instruction occupies EX, and the stall tally.
    logic                 m_valid = 1'b0;
    logic [CTRL_W-1:0]    m_ctrl = '0;
    logic [REG_IDX_W-1:0] m_rs1 = '0, m_rs2 = '0, m_rd = '0;
    logic [XLEN-1:0]      m_pc = '0, m_rs1_data = '0, m_rs2_data = '0, m_imm = '0;
    logic [FUNCT_W-1:0]   m_funct = '0;
    logic [31:0]          m_cnt = '0;

    function automatic logic m_hazard();
        logic reads_load;
        reads_load = (id_ctrl[CTRL_VREG_RS1] && id_rs1 == m_rd)
                  || (id_ctrl[CTRL_VREG_RS2] && id_rs2 == m_rd);
        return m_valid && m_ctrl[CTRL_MEMREAD] && (m_rd != 5'd0) && id_valid && reads_load;
    endfunction

    function automatic logic m_ready();
        logic slot_free;
        slot_free = !m_valid || ex_ready;
        return !rst && !flush && slot_free && !m_hazard();
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0; m_ctrl = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
            m_pc = '0; m_rs1_data = '0; m_rs2_data = '0; m_imm = '0; m_funct = '0;
            m_cnt = '0;
        end else begin
            logic take;
            logic leaves;
            take   = id_valid && m_ready();
            leaves = flush || ex_ready || !m_valid;
            if (m_hazard() && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (take) begin
                m_valid = 1'b1; m_ctrl = id_ctrl; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
                m_pc = id_pc; m_rs1_data = id_rs1_data; m_rs2_data = id_rs2_data;
                m_imm = id_imm; m_funct = id_funct;
            end else if (leaves) begin
                m_valid = 1'b0;
                m_ctrl  = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ex_valid", 64'(ex_valid), 64'(m_valid));
            check("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
            check("load_use_stall", 64'(load_use_stall), 64'(m_hazard()));
            check("id_ready", 64'(id_ready), 64'(m_ready()));
            check("stall_count", 64'(stall_count), 64'(m_cnt));
            if (m_valid) begin
                check("ex_pc", 64'(ex_pc), 64'(m_pc));
                check("ex_imm", 64'(ex_imm), 64'(m_imm));
                check("ex_rs_data", {ex_rs1_data, ex_rs2_data}, {m_rs1_data, m_rs2_data});
                check("ex_idx", 64'({ex_rs1, ex_rs2, ex_rd, ex_funct}),
                      64'({m_rs1, m_rs2, m_rd, m_funct}));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [CTRL_W-1:0] c, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] pc);
        id_valid    = 1'b1;
        id_ctrl     = c;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_pc       = pc;
        id_rs1_data = pc ^ 32'hA5A5_0000;
        id_rs2_data = ~pc;
        id_imm      = {20'h0, pc[11:0]} + 32'd4;
        id_funct    = pc[5:2];
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        drive(ctrl_of(OPC_OP_IMM), 5'd1, 5'd0, 5'd2, 32'h100);

        // Reset with a valid instruction offered
        cyc();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_id_ready", 64'(id_ready), 64'd0);
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_ex_ctrl", 64'(ex_ctrl), 64'd0);
        check("rst_stall_count", 64'(stall_count), 64'd0);
        check("rst_ex_pc", 64'(ex_pc), 64'd0);
        cyc();
        @(negedge clk);
        check("rst2_id_ready", 64'(id_ready), 64'd0);
        check("rst2_ex_valid", 64'(ex_valid), 64'd0);
        rst = 1'b0; id_valid = 1'b0;
        cyc();

        // Four back-to-back ADDI
        for (int i = 0; i < 4; i++) begin
            drive(ctrl_of(OPC_OP_IMM), 5'(i), 5'd0, 5'(i + 1), 32'h200 + 32'(4 * i));
            @(negedge clk);
            check("stream_id_ready", 64'(id_ready), 64'd1);
            if (i > 0) begin
                check("stream_ex_valid", 64'(ex_valid), 64'd1);
                check("stream_ex_pc", 64'(ex_pc), 64'(32'h200 + 32'(4 * (i - 1))));
            end
            cyc();
        end
        id_valid = 1'b0;
        @(negedge clk);
        check("stream_last_pc", 64'(ex_pc), 64'h20C);
        cyc();
        @(negedge clk);
        check("stream_drain", 64'(ex_valid), 64'd0);
        cyc();

        // LW x5 then ADD x7, x5, x6
        drive(ctrl_of(OPC_LOAD), 5'd2, 5'd0, 5'd5, 32'h300);
        cyc();
        drive(ctrl_of(OPC_OP), 5'd5, 5'd6, 5'd7, 32'h304);
        @(negedge clk);
        check("lw_ctrl_literal", 64'(ex_ctrl), 64'h0C78);
        check("lu_stall", 64'(load_use_stall), 64'd1);
        check("lu_id_ready", 64'(id_ready), 64'd0);
        cyc();
        @(negedge clk);
        check("lu_bubble", 64'(ex_valid), 64'd0);
        check("lu_stall_clear", 64'(load_use_stall), 64'd0);
        check("lu_count", 64'(stall_count), 64'd1);
        cyc();
        id_valid = 1'b0;
        @(negedge clk);
        check("lu_add_pc", 64'(ex_pc), 64'h304);
        check("lu_add_rd", 64'(ex_rd), 64'd7);
        cyc();

        // No false hazards: load to x0, LUI with rs1 field matching, illegal opcode
        drive(ctrl_of(OPC_LOAD), 5'd2, 5'd0, 5'd0, 32'h400);
        cyc();
        drive(ctrl_of(OPC_OP), 5'd0, 5'd0, 5'd8, 32'h404);
        @(negedge clk);
        check("x0_no_stall", 64'(load_use_stall), 64'd0);
        check("x0_id_ready", 64'(id_ready), 64'd1);
        cyc();
        drive(ctrl_of(OPC_LOAD), 5'd2, 5'd0, 5'd5, 32'h408);
        cyc();
        drive(ctrl_of(OPC_LUI), 5'd5, 5'd5, 5'd9, 32'h40C);
        @(negedge clk);
        check("lui_no_stall", 64'(load_use_stall), 64'd0);
        cyc();
        drive(ctrl_of(OPC_LOAD), 5'd2, 5'd0, 5'd5, 32'h410);
        cyc();
        drive(14'h0310, 5'd5, 5'd5, 5'd10, 32'h414);
        @(negedge clk);
        check("illegal_no_stall", 64'(load_use_stall), 64'd0);
        check("illegal_id_ready", 64'(id_ready), 64'd1);
        cyc();
        id_valid = 1'b0;
        @(negedge clk);
        check("illegal_ctrl_pass", 64'(ex_ctrl), 64'h0310);
        check("illegal_pc", 64'(ex_pc), 64'h414);
        cyc();

        // Hazard through rs2 only (store data)
        drive(ctrl_of(OPC_LOAD), 5'd2, 5'd0, 5'd9, 32'h500);
        cyc();
        drive(ctrl_of(OPC_STORE), 5'd3, 5'd9, 5'd0, 32'h504);
        @(negedge clk);
        check("rs2_stall", 64'(load_use_stall), 64'd1);
        cyc();
        @(negedge clk);
        check("rs2_count", 64'(stall_count), 64'd2);
        cyc();
        id_valid = 1'b0;
        @(negedge clk);
        check("rs2_store_pc", 64'(ex_pc), 64'h504);
        cyc();

        // Backpressure for 3 cycles, then flush with a valid incoming instruction
        drive(ctrl_of(OPC_OP_IMM), 5'd1, 5'd0, 5'd10, 32'h600);
        cyc();
        ex_ready = 1'b0;
        drive(ctrl_of(OPC_OP_IMM), 5'd1, 5'd0, 5'd11, 32'h604);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_id_ready", 64'(id_ready), 64'd0);
            check("bp_hold_pc", 64'(ex_pc), 64'h600);
            check("bp_hold_valid", 64'(ex_valid), 64'd1);
            cyc();
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush_id_ready", 64'(id_ready), 64'd0);
        cyc();
        flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        @(negedge clk);
        check("flush_ex_valid", 64'(ex_valid), 64'd0);
        check("flush_ex_ctrl", 64'(ex_ctrl), 64'd0);
        cyc();
        @(negedge clk);
        check("flush_not_captured", 64'(ex_valid), 64'd0);
        cyc();

        // Reset during a load-use stall
        drive(ctrl_of(OPC_LOAD), 5'd2, 5'd0, 5'd5, 32'h700);
        cyc();
        ex_ready = 1'b0;
        drive(ctrl_of(OPC_OP), 5'd5, 5'd1, 5'd12, 32'h704);
        @(negedge clk);
        check("rs_stall", 64'(load_use_stall), 64'd1);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("rs_id_ready", 64'(id_ready), 64'd0);
        cyc();
        rst = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        @(negedge clk);
        check("rs_ex_valid", 64'(ex_valid), 64'd0);
        check("rs_ex_pc", 64'(ex_pc), 64'd0);
        check("rs_ex_rs1_data", 64'(ex_rs1_data), 64'd0);
        check("rs_count", 64'(stall_count), 64'd0);
        cyc();

        // Counter saturation under a held hazard
        drive(ctrl_of(OPC_LOAD), 5'd2, 5'd0, 5'd5, 32'h800);
        cyc();
        ex_ready = 1'b0;
        drive(ctrl_of(OPC_OP), 5'd5, 5'd1, 5'd13, 32'h804);
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 32'hFFFF_FFFD;
        @(negedge clk);
        check("sat_preload", 64'(stall_count), 64'hFFFF_FFFD);
        cyc();
        @(negedge clk);
        check("sat_fe", 64'(stall_count), 64'hFFFF_FFFE);
        cyc();
        @(negedge clk);
        check("sat_ff", 64'(stall_count), 64'hFFFF_FFFF);
        cyc();
        @(negedge clk);
        check("sat_hold", 64'(stall_count), 64'hFFFF_FFFF);
        ex_ready = 1'b1; id_valid = 1'b0;
        cyc();
        cyc();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
